face_distance_unit: RTL
=======================

Name: face_distance_unit

Overview:
- Compute-side responder for the search controller's A/B/result handshakes.
- Stores one query face embedding (vector A, VEC_LEN signed elements) in a local buffer.
- Streams database embeddings (vector B) element by element and accumulates the squared Euclidean distance sum((A[i]-B[i])^2).
- Returns one result word per B vector; the controller forwards it to the FPGA-to-host FIFO.

Parameters:
- DATA_W, 8: element width, signed two's complement.
- VEC_LEN, 128: elements per vector; must be ≥2.
- RESULT_W, 32: accumulator/result width; sums wrap modulo 2^RESULT_W (no saturation). The default cannot overflow.

Ports:
- bus_clk  in  1  single clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- a_valid  in  1  query element valid (from controller).
- a_ready  out  1  query element accepted when a_valid&a_ready.
- a_data  in  DATA_W  query element, signed.
- b_valid  in  1  database element valid.
- b_ready  out  1  database element accepted when b_valid&b_ready.
- b_data  in  DATA_W  database element, signed.
- result_valid  out  1  distance available.
- result_ready  in  1  controller accepts result.
- result_data  out  RESULT_W  squared distance, unsigned.
- query_loaded  out  1  a complete query vector is held.

Behaviour:
- Reset (async assert, sync release): state=EMPTY, idx=0, acc=0, a_ready=0, b_ready=0, result_valid=0, result_data=0, query_loaded=0. Buffer contents are not cleared and are treated as invalid.
- States: EMPTY, LOAD_A, READY, RUN, DONE.
- EMPTY:
  - a_ready=1, b_ready=0.
  - On an A beat: write buf[0], idx=1, go to LOAD_A.
- LOAD_A:
  - a_ready=1, b_ready=0.
  - Each A beat writes buf[idx], idx++.
  - Beat at idx=VEC_LEN-1: idx=0, query_loaded=1, go to READY.
  - Gaps in a_valid are allowed.
- READY (vector boundary):
  - a_ready=1, b_ready=~a_valid. A has priority over B, so never both handshakes in one cycle.
  - A beat: query_loaded=0, write buf[0], idx=1, go to LOAD_A (query reload).
  - Otherwise B beat: acc=sq(buf[0]-b_data), idx=1, go to RUN.
- RUN:
  - a_ready=0, b_ready=1.
  - Each B beat: acc += sq(buf[idx]-b_data), idx++.
  - Beat at idx=VEC_LEN-1: result_data = final sum (acc + last term), result_valid=1, idx=0, go to DONE.
  - b_valid gaps stall without changing acc or idx.
- Latency: result_valid rises on the clock edge that accepts the last B beat, so it is visible the cycle after that beat.
- DONE:
  - a_ready=0, b_ready=0, result_valid=1, result_data held stable.
  - On result_valid&result_ready: result_valid=0, acc=0, go to READY. The next B beat is possible in the following cycle.
  - result_ready may be held high continuously; throughput is then VEC_LEN+1 cycles per vector.
- Arithmetic:
  - diff = sign-extended to DATA_W+1 bits.
  - square is 2*(DATA_W+1) bits, unsigned.
  - acc is zero-extended to RESULT_W.
- Buffer read:
  - buf is a VEC_LEN×DATA_W array, read combinationally at idx (distributed RAM).
  - idx width is clog2(VEC_LEN).
- Reset mid-operation (any state): immediate return to reset values. A partial result is never emitted, and a query reload is required.
- a_valid during RUN/DONE is ignored (a_ready=0). b_valid in EMPTY/LOAD_A is ignored.

Test Plan:
- Load A=all 0, stream B=all 3 with b_valid constant → one result_valid pulse, result_data=1152 (128×9), exactly 129 cycles from first B beat to result handshake, with result_ready=1.
- Load A[i]=i (0..127), B=all 0 → result_data=690880. Then stream B[i]=i without reloading → result_data=0, confirming query retention. query_loaded stays 1.
- Extremes: A=all -128, B=all 127 → result_data=8323200 (128×65025); then swap, with A=127 and B=-128 → same value.
- Backpressure: hold result_ready=0 for 5 cycles after result_valid → result_valid and result_data stable, b_ready=0 throughout; the first B beat is accepted only after the handshake. Insert random b_valid/a_valid gaps → same sums as gap-free runs.
- Reload at boundary: in READY drive a_valid=1 and b_valid=1 together → b_ready=0, A beat taken, query_loaded falls. The new query of all 1s against B of all 1s → 0.
- Assert rst after 50 B beats → all outputs reset values asynchronously, no result emitted, a_ready=1 after release. B ignored until a full query is reloaded, after which a fresh vector gives the correct sum.

Source files
------------

// File: rtl/face_distance_unit_if.sv
// Handshake bundle between the search controller and the face distance unit:
// query (A) stream, database (B) stream and result return path.
interface face_distance_unit_if #(
  parameter int DATA_W   = 8,
  parameter int RESULT_W = 32
);
  logic                a_valid;
  logic                a_ready;
  logic [DATA_W-1:0]   a_data;
  logic                b_valid;
  logic                b_ready;
  logic [DATA_W-1:0]   b_data;
  logic                result_valid;
  logic                result_ready;
  logic [RESULT_W-1:0] result_data;
  logic                query_loaded;

  modport master (
    output a_valid, a_data, b_valid, b_data, result_ready,
    input  a_ready, b_ready, result_valid, result_data, query_loaded
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data, result_ready,
    output a_ready, b_ready, result_valid, result_data, query_loaded
  );
endinterface

// File: rtl/face_distance_unit.sv
// Holds one query embedding and returns the squared Euclidean distance
// between it and each streamed database embedding.
module face_distance_unit #(
  parameter int DATA_W   = 8,
  parameter int VEC_LEN  = 128,
  parameter int RESULT_W = 32
) (
  input logic                bus_clk,
  input logic                rst,
  face_distance_unit_if.slave bus
);
  localparam int IDX_W = $clog2(VEC_LEN);
  localparam int SQ_W  = 2 * (DATA_W + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

  typedef enum logic [2:0] {EMPTY, LOAD_A, READY, RUN, DONE} state_t;

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [RESULT_W-1:0]     acc;
  logic [RESULT_W-1:0]     result_data_r;
  logic [RESULT_W-1:0]     term;
  logic                    a_ready_r;
  logic                    result_valid_r;
  logic                    query_loaded_r;
  logic                    b_ready_c;
  logic                    a_fire;
  logic                    b_fire;
  logic [DATA_W-1:0]       qbuf [VEC_LEN];
  logic signed [DATA_W:0]  diff;
  logic signed [SQ_W-1:0]  sq;

  // A wins over B at the vector boundary, so B is only offered when A is idle.
  assign b_ready_c = (state == RUN) || ((state == READY) && !bus.a_valid);
  assign a_fire    = bus.a_valid && a_ready_r;
  assign b_fire    = bus.b_valid && b_ready_c;

  assign bus.a_ready      = a_ready_r;
  assign bus.b_ready      = b_ready_c;
  assign bus.result_valid = result_valid_r;
  assign bus.result_data  = result_data_r;
  assign bus.query_loaded = query_loaded_r;

  always_comb begin
    diff = $signed({qbuf[idx][DATA_W-1], qbuf[idx]}) -
           $signed({bus.b_data[DATA_W-1], bus.b_data});
    sq   = diff * diff;
    term = RESULT_W'($unsigned(sq));
  end

  // idx is 0 in EMPTY and READY, so every accepted A beat lands at buf[idx].
  always_ff @(posedge bus_clk) begin
    if (a_fire) begin
      qbuf[idx] <= bus.a_data;
    end
  end

  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) begin
      state          <= EMPTY;
      idx            <= '0;
      acc            <= '0;
      a_ready_r      <= 1'b0;
      result_valid_r <= 1'b0;
      result_data_r  <= '0;
      query_loaded_r <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          a_ready_r <= 1'b1;
          if (a_fire) begin
            idx   <= IDX_W'(1);
            state <= LOAD_A;
          end
        end
        LOAD_A: begin
          if (a_fire) begin
            if (idx == LAST_IDX) begin
              idx            <= '0;
              query_loaded_r <= 1'b1;
              state          <= READY;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        READY: begin
          if (a_fire) begin
            query_loaded_r <= 1'b0;
            idx            <= IDX_W'(1);
            state          <= LOAD_A;
          end else if (b_fire) begin
            acc       <= term;
            idx       <= IDX_W'(1);
            a_ready_r <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (b_fire) begin
            if (idx == LAST_IDX) begin
              result_data_r  <= acc + term;
              result_valid_r <= 1'b1;
              idx            <= '0;
              state          <= DONE;
            end else begin
              acc <= acc + term;
              idx <= idx + IDX_W'(1);
            end
          end
        end
        DONE: begin
          if (bus.result_ready) begin
            result_valid_r <= 1'b0;
            acc            <= '0;
            a_ready_r      <= 1'b1;
            state          <= READY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end
endmodule
